// File: rtl/genius_seq_engine.sv
// -----------------------------------------------------------------------------
// genius_seq_engine
//
// Run-time generated Genius colour sequence. A free-running 16-bit Fibonacci
// LFSR supplies colour indices. Each round the stored sequence is played out on
// one-hot LEDs, and then the player's presses are checked step by step. A
// correct final press extends the sequence by one colour, up to DEPTH rounds.
//
// Optional feature macro: GENIUS_TIMEOUT_EN
//   When this macro is defined, INPUT gives up after TIMEOUT_CYCLES idle cycles
//   and moves to LOSE. When it is undefined, no timer is built.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   new_game      single-cycle start pulse. Accepted in every state and has
//                 the highest priority.
//   player_valid  single-cycle press strobe
//   player_color  one-hot pressed colour, qualified by player_valid
//   led_out       one-hot LED drive. All zero when the LEDs are dark.
//   round_len     current sequence length
//   busy          high during playback (PLAY_ON / PLAY_OFF)
//   wait_input    high while waiting for presses (INPUT)
//   step_ok       one-cycle pulse after each correct press
//   game_over     level, high in LOSE
//   game_win      level, high in WIN
//
// Handshake: player_valid/player_color have no ready signal. A strobe is
// consumed on the edge where it is sampled high, and only while the state is
// INPUT. In every other state the strobe is dropped.
// -----------------------------------------------------------------------------
module genius_seq_engine #(
  parameter int          N_COLORS       = 4,
  parameter int          DEPTH          = 16,
  parameter int          ON_CYCLES      = 8,
  parameter int          OFF_CYCLES     = 4,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     new_game,
  input  logic                     player_valid,
  input  logic [N_COLORS-1:0]      player_color,
  output logic [N_COLORS-1:0]      led_out,
  output logic [$clog2(DEPTH):0]   round_len,
  output logic                     busy,
  output logic                     wait_input,
  output logic                     step_ok,
  output logic                     game_over,
  output logic                     game_win
);

  localparam int CW      = $clog2(N_COLORS);
  localparam int IW      = $clog2(DEPTH);
  localparam int RW      = IW + 1;
  localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int NW      = $clog2(CNT_MAX + 1);

  localparam logic [NW-1:0] ON_LAST  = NW'(ON_CYCLES - 1);
  localparam logic [NW-1:0] OFF_LAST = NW'(OFF_CYCLES - 1);
  localparam logic [NW-1:0] CNT_ONE  = NW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [RW-1:0] LEN_ONE  = RW'(1);
  localparam logic [RW-1:0] LEN_MAX  = RW'(DEPTH);

  // Parameter legality is checked at elaboration time.
  if (N_COLORS < 2 || N_COLORS > 8 || (N_COLORS & (N_COLORS - 1)) != 0 ||
      DEPTH < 2 || DEPTH > 64 || ON_CYCLES < 1 || OFF_CYCLES < 1 ||
      SEED == 16'h0000 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("genius_seq_engine: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY_ON  = 3'd1,
    S_PLAY_OFF = 3'd2,
    S_INPUT    = 3'd3,
    S_GAP      = 3'd4,
    S_LOSE     = 3'd5,
    S_WIN      = 3'd6
  } state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic [CW-1:0]   seq [DEPTH];
  logic [IW-1:0]   idx;
  logic [NW-1:0]   cnt;

`ifdef GENIUS_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  logic [TW-1:0] timer;
`endif

  // The LFSR uses taps 16,14,13,11. Bit 15 is the oldest bit.
  logic          lfsr_fb;
  logic [CW-1:0] new_color;
  logic [CW-1:0] cur_color;
  logic [N_COLORS-1:0] cur_onehot;
  logic          is_last;
  logic          at_depth;

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign new_color = lfsr[CW-1:0];
  assign cur_color = seq[idx];
  assign is_last   = (({1'b0, idx} + LEN_ONE) == round_len);
  assign at_depth  = (round_len == LEN_MAX);

  always_comb begin
    cur_onehot            = '0;
    cur_onehot[cur_color] = 1'b1;
  end

  // All outputs here are decoded from registers only. No input reaches them
  // combinationally.
  always_comb begin
    led_out    = (state == S_PLAY_ON) ? cur_onehot : '0;
    busy       = (state == S_PLAY_ON) || (state == S_PLAY_OFF);
    wait_input = (state == S_INPUT);
    game_over  = (state == S_LOSE);
    game_win   = (state == S_WIN);
  end

  // The sequence array is deliberately left out of reset. Its entries are
  // always written before they are read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      round_len <= '0;
      idx       <= '0;
      cnt       <= '0;
      step_ok   <= 1'b0;
`ifdef GENIUS_TIMEOUT_EN
      timer     <= '0;
`endif
    end else begin
      lfsr    <= {lfsr[14:0], lfsr_fb};
      step_ok <= 1'b0;
      if (new_game) begin
        seq[0]    <= new_color;
        round_len <= LEN_ONE;
        idx       <= '0;
        cnt       <= '0;
        state     <= S_PLAY_ON;
      end else begin
        case (state)
          S_PLAY_ON: begin
            if (cnt == ON_LAST) begin
              cnt   <= '0;
              state <= S_PLAY_OFF;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_PLAY_OFF: begin
            if (cnt == OFF_LAST) begin
              cnt <= '0;
              if (!is_last) begin
                idx   <= idx + IDX_ONE;
                state <= S_PLAY_ON;
              end else begin
                idx   <= '0;
                state <= S_INPUT;
`ifdef GENIUS_TIMEOUT_EN
                timer <= '0;
`endif
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_INPUT: begin
            if (player_valid) begin
`ifdef GENIUS_TIMEOUT_EN
              timer <= '0;
`endif
              // A zero or multi-bit colour can never equal the one-hot
              // expected value, so such a press falls through to LOSE.
              if (player_color == cur_onehot) begin
                step_ok <= 1'b1;
                if (!is_last) begin
                  idx <= idx + IDX_ONE;
                end else if (at_depth) begin
                  state <= S_WIN;
                end else begin
                  // Here round_len < DEPTH, so the write index stays in range.
                  seq[round_len[IW-1:0]] <= new_color;
                  round_len <= round_len + LEN_ONE;
                  idx       <= '0;
                  cnt       <= '0;
                  state     <= S_GAP;
                end
              end else begin
                state <= S_LOSE;
              end
            end
`ifdef GENIUS_TIMEOUT_EN
            else if (timer == TO_LAST) begin
              state <= S_LOSE;
            end else begin
              timer <= timer + TMR_ONE;
            end
`endif
          end
          S_GAP: begin
            if (cnt == OFF_LAST) begin
              cnt   <= '0;
              idx   <= '0;
              state <= S_PLAY_ON;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_IDLE, S_LOSE, S_WIN: begin
            state <= state;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/genius_seq_engine.md
Name: genius_seq_engine

Overview:
Parametrised successor to the fixed 16-entry Genius colour-sequence ROM. Generates the game sequence at run time from an internal LFSR and stores it in a DEPTH-entry register array. Plays the current round out on one-hot LEDs with programmable on/off timing, then checks the player's one-hot presses step by step. Sits between the button debouncers and the LED drivers in the game top level.

Parameters:
N_COLORS, 4, number of colour channels; power of two, 2..8.
DEPTH, 16, maximum sequence length (rounds to win); 2..64.
ON_CYCLES, 8, clock cycles each LED is lit during playback; >=1.
OFF_CYCLES, 4, dark gap after each lit step and before each new round; >=1.
SEED, 16'hACE1, LFSR reset value; nonzero.
TIMEOUT_CYCLES, 64, input timeout length; used only with GENIUS_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
new_game  in  1  single-cycle start pulse.
player_valid  in  1  single-cycle press strobe.
player_color  in  N_COLORS  one-hot pressed colour, qualified by player_valid.
led_out  out  N_COLORS  one-hot LED drive; all zero when dark.
round_len  out  clog2(DEPTH)+1  current sequence length.
busy  out  1  high in PLAY_ON/PLAY_OFF.
wait_input  out  1  high in INPUT.
step_ok  out  1  one-cycle pulse on each correct press.
game_over  out  1  level, high in LOSE.
game_win  out  1  level, high in WIN.

Behaviour:
- Reset, sampled on a rising clk edge with rst_n=0: state IDLE; lfsr=SEED; round_len=0; idx=0; cnt=0; all outputs 0; the sequence array is not cleared.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle outside reset. New colour index = lfsr[clog2(N_COLORS)-1:0] at the sampling edge.
- new_game is accepted in every state and takes priority over all other events. On the accepting edge: seq[0] = new colour; round_len=1; idx=0; cnt=0; state PLAY_ON.
- PLAY_ON: led_out = onehot(seq[idx]) for exactly ON_CYCLES cycles, then PLAY_OFF with cnt=0.
- PLAY_OFF: led_out=0 for OFF_CYCLES cycles. Then:
  - if idx < round_len-1: idx++, go to PLAY_ON;
  - otherwise: idx=0, go to INPUT.
- INPUT: player_valid is acted on only in this state; it is ignored in all other states.
  - On player_valid with player_color == onehot(seq[idx]): step_ok pulses next cycle.
    - If idx < round_len-1: idx++.
    - Else if round_len == DEPTH: go to WIN.
    - Else: seq[round_len] = new colour; round_len++; idx=0; go to GAP.
  - On player_valid with a wrong colour, or with player_color not one-hot (zero or multiple bits set): go to LOSE.
- GAP: led_out=0 for OFF_CYCLES cycles, then PLAY_ON with idx=0.
- LOSE / WIN: led_out=0; game_over (or game_win) held high until new_game or reset. round_len is held.
- Output decode: led_out, busy, wait_input, game_over and game_win are decoded from registered state only; no combinational path from any input.
- Reset mid-playback or mid-input: immediate return to IDLE with the reset values above.
- round_len never exceeds DEPTH; writes to seq never address index DEPTH or above.

Optional Feature:
GENIUS_TIMEOUT_EN
- Defined: a timer clears on entry to INPUT and on each accepted press. If it reaches TIMEOUT_CYCLES in INPUT with no player_valid, state goes to LOSE. A press on that same cycle wins over the timeout.
- Undefined: INPUT waits indefinitely; no timer logic is synthesised.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> led_out=0, round_len=0, busy=0, game_over=0, game_win=0; player_valid pulses in IDLE have no effect.
- new_game pulse -> from the next cycle led_out is one-hot for exactly 8 cycles, then 0 for 4 cycles; wait_input=1 and round_len=1.
- Press the observed colour -> step_ok pulses once; 4-cycle dark gap; round 2 replays the same first colour followed by a new one-hot colour; round_len=2.
- In round 2, press the correct first colour, then a wrong colour -> one step_ok pulse, then game_over=1 and led_out=0; new_game then restarts with round_len=1.
- player_color=4'b0011 with player_valid in INPUT -> game_over=1. Separately, a reset pulse during PLAY_ON -> IDLE next cycle with all outputs 0.
- DEPTH=4 override, all presses correct -> game_win=1 after the 4th round's last press, round_len=4. With GENIUS_TIMEOUT_EN and TIMEOUT_CYCLES=10, idling in INPUT for 10 cycles -> game_over=1.
